// File: rtl/ariane_regfile_pkg.sv
// Shared definitions for the ariane register file with pending-write scoreboard.
// Contents:
//   DEFAULT_NR_REGS / DEFAULT_DATA_WIDTH : default geometry of the register file
//   regaddr_t                            : register index at the default geometry
//   wr_port_t                            : one write port {addr, data, we}
package ariane_regfile_pkg;

  localparam int unsigned DEFAULT_NR_REGS    = 32;
  localparam int unsigned DEFAULT_DATA_WIDTH = 64;
  localparam int unsigned DEFAULT_ADDR_W     = $clog2(DEFAULT_NR_REGS);

  typedef logic [DEFAULT_ADDR_W-1:0] regaddr_t;

  typedef struct packed {
    regaddr_t                      addr;
    logic [DEFAULT_DATA_WIDTH-1:0] data;
    logic                          we;
  } wr_port_t;

endpackage

// File: rtl/ariane_regfile_wr_arb.sv
// Combinational write-port resolver.
// For every register it reports whether any enabled write port targets it
// (hit) and which data wins (hit_data). Ports are scanned in ascending index
// order, so the highest-index enabled port wins a conflict. With
// ZERO_REG_ZERO set, register 0 never reports a hit.
// Ports:
//   waddr    in  NR_WRITE_PORTS x ADDR_W      write addresses
//   wdata    in  NR_WRITE_PORTS x DATA_WIDTH  write data
//   we       in  NR_WRITE_PORTS               write enables
//   hit      out NR_REGS                      register is written this cycle
//   hit_data out NR_REGS x DATA_WIDTH         winning data per register (0 if no hit)
module ariane_regfile_wr_arb
  import ariane_regfile_pkg::*;
#(
  parameter int unsigned DATA_WIDTH     = DEFAULT_DATA_WIDTH,
  parameter int unsigned NR_REGS        = DEFAULT_NR_REGS,
  parameter int unsigned NR_WRITE_PORTS = 2,
  parameter int unsigned ZERO_REG_ZERO  = 1,
  localparam int unsigned ADDR_W        = $clog2(NR_REGS)
) (
  input  logic [NR_WRITE_PORTS-1:0][ADDR_W-1:0]     waddr,
  input  logic [NR_WRITE_PORTS-1:0][DATA_WIDTH-1:0] wdata,
  input  logic [NR_WRITE_PORTS-1:0]                 we,
  output logic [NR_REGS-1:0]                        hit,
  output logic [NR_REGS-1:0][DATA_WIDTH-1:0]        hit_data
);

  always_comb begin
    hit      = '0;
    hit_data = '0;
    for (int r = 0; r < int'(NR_REGS); r++) begin
      for (int p = 0; p < int'(NR_WRITE_PORTS); p++) begin
        // Later (higher-index) ports overwrite earlier ones: highest wins.
        if (we[p] && (waddr[p] == ADDR_W'(r))) begin
          hit[r]      = 1'b1;
          hit_data[r] = wdata[p];
        end
      end
    end
    if (ZERO_REG_ZERO != 0) begin
      hit[0]      = 1'b0;
      hit_data[0] = '0;
    end
  end

endmodule

// File: rtl/ariane_regfile_sb.sv
// Multi-port register file with a per-register pending-write scoreboard.
// Reads are registered (one cycle latency) with optional write-first bypass.
// The busy vector marks registers that have an allocated, not yet written,
// producer; issue uses it for RAW/WAW hazard checks.
// Ports:
//   clk_i         in  clock, rising edge
//   rst_i         in  synchronous active-high reset
//   raddr_i       in  read addresses, sampled every edge
//   rdata_o       out read data, one cycle after raddr_i
//   rbusy_o       out busy flag of the read register, aligned with rdata_o
//   waddr_i       in  write addresses
//   wdata_i       in  write data
//   we_i          in  per-port write enables
//   alloc_valid_i in  request to mark alloc_addr_i as pending
//   alloc_addr_i  in  register to allocate
//   alloc_ready_o out allocation accepted this cycle (combinational)
//   busy_o        out current busy vector
module ariane_regfile_sb
  import ariane_regfile_pkg::*;
#(
  parameter int unsigned DATA_WIDTH     = DEFAULT_DATA_WIDTH,
  parameter int unsigned NR_REGS        = DEFAULT_NR_REGS,
  parameter int unsigned NR_READ_PORTS  = 2,
  parameter int unsigned NR_WRITE_PORTS = 2,
  parameter int unsigned ZERO_REG_ZERO  = 1,
  parameter int unsigned BYPASS_EN      = 1,
  localparam int unsigned ADDR_W        = $clog2(NR_REGS)
) (
  input  logic                                      clk_i,
  input  logic                                      rst_i,
  input  logic [NR_READ_PORTS-1:0][ADDR_W-1:0]      raddr_i,
  output logic [NR_READ_PORTS-1:0][DATA_WIDTH-1:0]  rdata_o,
  output logic [NR_READ_PORTS-1:0]                  rbusy_o,
  input  logic [NR_WRITE_PORTS-1:0][ADDR_W-1:0]     waddr_i,
  input  logic [NR_WRITE_PORTS-1:0][DATA_WIDTH-1:0] wdata_i,
  input  logic [NR_WRITE_PORTS-1:0]                 we_i,
  input  logic                                      alloc_valid_i,
  input  logic [ADDR_W-1:0]                         alloc_addr_i,
  output logic                                      alloc_ready_o,
  output logic [NR_REGS-1:0]                        busy_o
);

  logic [DATA_WIDTH-1:0]                   mem [NR_REGS];
  logic [NR_REGS-1:0]                      hit;
  logic [NR_REGS-1:0][DATA_WIDTH-1:0]      hit_data;
  logic [NR_REGS-1:0]                      set_mask;
  logic [NR_REGS-1:0]                      busy_d;
  logic [NR_READ_PORTS-1:0][DATA_WIDTH-1:0] rdata_d;
  logic [NR_READ_PORTS-1:0]                rbusy_d;
  logic                                    alloc_zero;

  ariane_regfile_wr_arb #(
    .DATA_WIDTH     (DATA_WIDTH),
    .NR_REGS        (NR_REGS),
    .NR_WRITE_PORTS (NR_WRITE_PORTS),
    .ZERO_REG_ZERO  (ZERO_REG_ZERO)
  ) u_wr_arb (
    .waddr    (waddr_i),
    .wdata    (wdata_i),
    .we       (we_i),
    .hit      (hit),
    .hit_data (hit_data)
  );

  // Allocation handshake: a transfer happens on an edge where alloc_valid_i
  // and alloc_ready_o are both 1. Ready depends only on the current busy
  // state, never on a same-cycle write, so a WAW stall lasts at least until
  // the edge at which the pending producer writes back. The requester keeps
  // alloc_valid_i and alloc_addr_i stable until it sees ready.
  assign alloc_zero    = (ZERO_REG_ZERO != 0) && (alloc_addr_i == '0);
  assign alloc_ready_o = alloc_valid_i & (alloc_zero | ~busy_o[alloc_addr_i]);

  // Set has priority over clear so a new producer allocated in the cycle its
  // predecessor writes back stays tracked.
  always_comb begin
    set_mask = '0;
    if (alloc_ready_o && !alloc_zero) set_mask[alloc_addr_i] = 1'b1;
    busy_d = (busy_o & ~hit) | set_mask;
  end

  always_comb begin
    rdata_d = '0;
    rbusy_d = '0;
    for (int r = 0; r < int'(NR_READ_PORTS); r++) begin
      if ((BYPASS_EN != 0) && hit[raddr_i[r]]) rdata_d[r] = hit_data[raddr_i[r]];
      else                                     rdata_d[r] = mem[raddr_i[r]];
      rbusy_d[r] = busy_d[raddr_i[r]];
      if ((ZERO_REG_ZERO != 0) && (raddr_i[r] == '0)) begin
        rdata_d[r] = '0;
        rbusy_d[r] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int r = 0; r < int'(NR_REGS); r++) mem[r] <= '0;
      busy_o  <= '0;
      rdata_o <= '0;
      rbusy_o <= '0;
    end else begin
      for (int r = 0; r < int'(NR_REGS); r++) begin
        if (hit[r]) mem[r] <= hit_data[r];
      end
      busy_o  <= busy_d;
      rdata_o <= rdata_d;
      rbusy_o <= rbusy_d;
    end
  end

endmodule

// File: tb/tb_ariane_regfile_sb.sv
// Bench for ariane_regfile_sb: one instance with bypass, one without, both
// driven by the same stimulus. A directed table with hand-derived values,
// then random traffic checked against a behavioural model via a queue.
module tb_ariane_regfile_sb;

  localparam int DW = 64;
  localparam int NR = 32;
  localparam int AW = 5;
  localparam int W  = 4*DW + 2 + NR;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                   rst;
  logic [1:0][AW-1:0]     raddr;
  logic [1:0][AW-1:0]     waddr;
  logic [1:0][DW-1:0]     wdata;
  logic [1:0]             we;
  logic                   av;
  logic [AW-1:0]          aa;
  logic [1:0][DW-1:0]     rdata_b, rdata_n;
  logic [1:0]             rbusy_b, rbusy_n;
  logic                   ready_b, ready_n;
  logic [NR-1:0]          busy_b, busy_n;

  ariane_regfile_sb #(.BYPASS_EN(1)) dut (
    .clk_i(clk), .rst_i(rst), .raddr_i(raddr), .rdata_o(rdata_b), .rbusy_o(rbusy_b),
    .waddr_i(waddr), .wdata_i(wdata), .we_i(we), .alloc_valid_i(av),
    .alloc_addr_i(aa), .alloc_ready_o(ready_b), .busy_o(busy_b)
  );

  ariane_regfile_sb #(.BYPASS_EN(0)) dut_nb (
    .clk_i(clk), .rst_i(rst), .raddr_i(raddr), .rdata_o(rdata_n), .rbusy_o(rbusy_n),
    .waddr_i(waddr), .wdata_i(wdata), .we_i(we), .alloc_valid_i(av),
    .alloc_addr_i(aa), .alloc_ready_o(ready_n), .busy_o(busy_n)
  );

  typedef struct {
    logic          rst;
    logic [AW-1:0] ra0, ra1;
    logic          we0;
    logic [AW-1:0] wa0;
    logic [DW-1:0] wd0;
    logic          we1;
    logic [AW-1:0] wa1;
    logic [DW-1:0] wd1;
    logic          av;
    logic [AW-1:0] aa;
    logic          exp_ready;
    logic [DW-1:0] exp_rd0, exp_rd1;
  } vec_t;

  int errors = 0;
  int checks = 0;
  logic [W-1:0]  exp_q[$];
  logic [DW-1:0] m_mem [NR];
  logic [NR-1:0] m_busy;
  vec_t          tbl [16];

  function automatic vec_t mk(logic r, int ra0, int ra1,
                              logic we0, int wa0, logic [DW-1:0] wd0,
                              logic we1, int wa1, logic [DW-1:0] wd1,
                              logic av_, int aa_, logic er,
                              logic [DW-1:0] e0, logic [DW-1:0] e1);
    vec_t v;
    v.rst = r; v.ra0 = AW'(ra0); v.ra1 = AW'(ra1);
    v.we0 = we0; v.wa0 = AW'(wa0); v.wd0 = wd0;
    v.we1 = we1; v.wa1 = AW'(wa1); v.wd1 = wd1;
    v.av = av_; v.aa = AW'(aa_); v.exp_ready = er;
    v.exp_rd0 = e0; v.exp_rd1 = e1;
    return v;
  endfunction

  task automatic check(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // One cycle: drive on the falling edge, predict, compare after the rise.
  task automatic run_vec(input vec_t v, input logic use_tbl, input int idx);
    logic [DW-1:0] nmem [NR];
    logic [NR-1:0] nbusy;
    logic [DW-1:0] rdb0, rdb1, rdn0, rdn1;
    logic [1:0]    rb;
    logic          m_ready;
    logic [W-1:0]  e;
    @(negedge clk);
    rst = v.rst; raddr[0] = v.ra0; raddr[1] = v.ra1;
    we[0] = v.we0; waddr[0] = v.wa0; wdata[0] = v.wd0;
    we[1] = v.we1; waddr[1] = v.wa1; wdata[1] = v.wd1;
    av = v.av; aa = v.aa;
    #1;
    m_ready = v.av && ((v.aa == '0) || !m_busy[v.aa]);
    check($sformatf("ready_b[%0d]", idx), 64'(ready_b), 64'(m_ready));
    check($sformatf("ready_n[%0d]", idx), 64'(ready_n), 64'(m_ready));
    if (use_tbl) check($sformatf("tbl_ready[%0d]", idx), 64'(ready_b), 64'(v.exp_ready));
    for (int r = 0; r < NR; r++) nmem[r] = m_mem[r];
    nbusy = m_busy;
    if (v.rst) begin
      for (int r = 0; r < NR; r++) nmem[r] = '0;
      nbusy = '0;
      rdb0 = '0; rdb1 = '0; rdn0 = '0; rdn1 = '0; rb = '0;
    end else begin
      if (v.we0 && v.wa0 != '0) begin nmem[v.wa0] = v.wd0; nbusy[v.wa0] = 1'b0; end
      if (v.we1 && v.wa1 != '0) begin nmem[v.wa1] = v.wd1; nbusy[v.wa1] = 1'b0; end
      if (m_ready && v.aa != '0) nbusy[v.aa] = 1'b1;
      rdb0 = (v.ra0 == '0) ? '0 : nmem[v.ra0];
      rdb1 = (v.ra1 == '0) ? '0 : nmem[v.ra1];
      rdn0 = (v.ra0 == '0) ? '0 : m_mem[v.ra0];
      rdn1 = (v.ra1 == '0) ? '0 : m_mem[v.ra1];
      rb   = {nbusy[v.ra1], nbusy[v.ra0]};
    end
    exp_q.push_back({nbusy, rb, rdn1, rdn0, rdb1, rdb0});
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      errors++; checks++;
      $display("FAIL queue_empty[%0d]: got 0 entries expected 1", idx);
    end else begin
      e = exp_q.pop_front();
      check($sformatf("rd_b0[%0d]", idx), rdata_b[0], e[DW-1:0]);
      check($sformatf("rd_b1[%0d]", idx), rdata_b[1], e[2*DW-1:DW]);
      check($sformatf("rd_n0[%0d]", idx), rdata_n[0], e[3*DW-1:2*DW]);
      check($sformatf("rd_n1[%0d]", idx), rdata_n[1], e[4*DW-1:3*DW]);
      check($sformatf("rbusy_b[%0d]", idx), 64'(rbusy_b), 64'(e[4*DW+1:4*DW]));
      check($sformatf("rbusy_n[%0d]", idx), 64'(rbusy_n), 64'(e[4*DW+1:4*DW]));
      check($sformatf("busy_b[%0d]", idx), 64'(busy_b), 64'(e[W-1:4*DW+2]));
      check($sformatf("busy_n[%0d]", idx), 64'(busy_n), 64'(e[W-1:4*DW+2]));
    end
    if (use_tbl) begin
      check($sformatf("tbl_rd0[%0d]", idx), rdata_b[0], v.exp_rd0);
      check($sformatf("tbl_rd1[%0d]", idx), rdata_b[1], v.exp_rd1);
    end
    for (int r = 0; r < NR; r++) m_mem[r] = nmem[r];
    m_busy = nbusy;
  endtask

  initial begin
    vec_t v;
    rst = 1'b1; raddr = '0; waddr = '0; wdata = '0; we = '0; av = 1'b0; aa = '0;
    for (int r = 0; r < NR; r++) m_mem[r] = '0;
    m_busy = '0;

    //            rst ra0 ra1 we0 wa0 wd0      we1 wa1 wd1   av aa rdy rd0      rd1
    tbl[0]  = mk(1, 0, 0, 0, 0, 0,        0, 0, 0,     0, 0, 0, 0,        0);
    tbl[1]  = mk(0, 5, 5, 0, 0, 0,        0, 0, 0,     0, 0, 0, 0,        0);
    tbl[2]  = mk(0, 3, 3, 1, 3, 'hAAAA,   0, 0, 0,     0, 0, 0, 'hAAAA,   'hAAAA);
    tbl[3]  = mk(0, 3, 3, 0, 0, 0,        0, 0, 0,     0, 0, 0, 'hAAAA,   'hAAAA);
    tbl[4]  = mk(0, 7, 0, 1, 7, 'h11,     1, 7, 'h22,  0, 0, 0, 'h22,     0);
    tbl[5]  = mk(0, 7, 7, 0, 0, 0,        0, 0, 0,     0, 0, 0, 'h22,     'h22);
    tbl[6]  = mk(0, 9, 0, 0, 0, 0,        0, 0, 0,     1, 9, 1, 0,        0);
    tbl[7]  = mk(0, 9, 0, 0, 0, 0,        0, 0, 0,     1, 9, 0, 0,        0);
    tbl[8]  = mk(0, 9, 0, 1, 9, 'h5,      0, 0, 0,     0, 0, 0, 'h5,      0);
    tbl[9]  = mk(0, 9, 0, 0, 0, 0,        0, 0, 0,     1, 9, 1, 'h5,      0);
    tbl[10] = mk(0, 4, 0, 0, 0, 0,        1, 4, 'h44,  1, 4, 1, 'h44,     0);
    tbl[11] = mk(0, 0, 4, 1, 0, 'hFF,     0, 0, 0,     0, 0, 0, 0,        'h44);
    tbl[12] = mk(0, 0, 0, 0, 0, 0,        0, 0, 0,     1, 0, 1, 0,        0);
    tbl[13] = mk(0, 2, 0, 1, 2, 'h1234,   0, 0, 0,     1, 2, 1, 'h1234,   0);
    tbl[14] = mk(1, 2, 0, 1, 2, 'h77,     0, 0, 0,     0, 0, 0, 0,        0);
    tbl[15] = mk(0, 2, 9, 0, 0, 0,        0, 0, 0,     0, 0, 0, 0,        0);

    for (int i = 0; i < 16; i++) run_vec(tbl[i], 1'b1, i);

    // Hand-checked boundary state after the directed sequence.
    check("busy_after_reset", 64'(busy_b), 64'd0);

    // Hold an allocation on a busy register until its producer writes back.
    run_vec(mk(0, 6, 0, 0, 0, 0, 0, 0, 0, 1, 6, 1, 0, 0), 1'b1, 100);
    run_vec(mk(0, 6, 0, 0, 0, 0, 0, 0, 0, 1, 6, 0, 0, 0), 1'b1, 101);
    run_vec(mk(0, 6, 0, 0, 0, 0, 1, 6, 'h66, 1, 6, 0, 'h66, 0), 1'b1, 102);
    check("waw_busy_cleared", 64'(busy_b[6]), 64'd0);
    run_vec(mk(0, 6, 0, 0, 0, 0, 0, 0, 0, 1, 6, 1, 'h66, 0), 1'b1, 103);
    check("waw_realloc_busy", 64'(busy_b[6]), 64'd1);
    check("waw_rbusy", 64'(rbusy_b[0]), 64'd1);

    // Random traffic over a narrow address range to force conflicts.
    for (int i = 0; i < 300; i++) begin
      v.rst = ($urandom_range(0, 49) == 0);
      v.ra0 = AW'($urandom_range(0, 15)); v.ra1 = AW'($urandom_range(0, 15));
      v.we0 = 1'($urandom_range(0, 1));   v.wa0 = AW'($urandom_range(0, 15));
      v.wd0 = {$urandom, $urandom};
      v.we1 = 1'($urandom_range(0, 1));   v.wa1 = AW'($urandom_range(0, 15));
      v.wd1 = {$urandom, $urandom};
      v.av  = !v.rst && ($urandom_range(0, 1) == 1);
      v.aa  = AW'($urandom_range(0, 15));
      v.exp_ready = 1'b0; v.exp_rd0 = '0; v.exp_rd1 = '0;
      run_vec(v, 1'b0, 1000 + i);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
